// File: rtl/mem_timer_pkg.sv
// Shared definitions for the memory-mapped timer bank:
// register word indices, field positions and a byte-enable merge helper.
package mem_timer_pkg;

    localparam int REG_MTIME      = 0;
    localparam int REG_CTRL       = 1;
    localparam int REG_GPIO_OUT   = 2;
    localparam int REG_GPIO_IN    = 3;
    localparam int REG_IRQ_STATUS = 4;
    localparam int REG_IRQ_EN     = 5;
    localparam int REG_CMP_BASE   = 8;

    localparam int CFG_EN_BIT  = 0;
    localparam int CFG_PER_BIT = 1;
    localparam int CFG_IVL_LSB = 32;
    localparam int CTRL_EN_BIT = 32;

    function automatic logic [63:0] be_merge(
        input logic [63:0] old_v,
        input logic [63:0] new_v,
        input logic [7:0]  be
    );
        logic [63:0] res;
        for (int b = 0; b < 8; b++) begin
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_timer_chan.sv
// One compare channel: compare value, config, fire detection,
// periodic reload and one-shot auto-disable.
module mem_timer_chan
    import mem_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] i_mtime,
    input  logic        i_cmp_we,
    input  logic        i_cfg_we,
    input  logic [7:0]  i_be,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_cmp,
    output logic [63:0] o_cfg,
    output logic        o_fire
);

    logic [63:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        per_q, per_d;
    logic [31:0] ivl_q, ivl_d;
    logic [63:0] cfg_m;
    logic        unused_ok;

    assign o_cmp  = cmp_q;
    assign o_fire = en_q & (i_mtime >= cmp_q);

    always_comb begin
        o_cfg = '0;
        o_cfg[CFG_EN_BIT]        = en_q;
        o_cfg[CFG_PER_BIT]       = per_q;
        o_cfg[63:CFG_IVL_LSB]    = ivl_q;
    end

    assign cfg_m     = be_merge(o_cfg, i_wdata, i_be);
    assign unused_ok = ^cfg_m;

    // Software writes are applied last so they win over hardware updates.
    always_comb begin
        cmp_d = cmp_q;
        en_d  = en_q;
        per_d = per_q;
        ivl_d = ivl_q;
        if (o_fire) begin
            if (per_q) cmp_d = cmp_q + {32'd0, ivl_q};
            else       en_d  = 1'b0;
        end
        if (i_cmp_we) cmp_d = be_merge(cmp_q, i_wdata, i_be);
        if (i_cfg_we) begin
            en_d  = cfg_m[CFG_EN_BIT];
            per_d = cfg_m[CFG_PER_BIT];
            ivl_d = cfg_m[63:CFG_IVL_LSB];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q <= '1;
            en_q  <= 1'b0;
            per_q <= 1'b0;
            ivl_q <= '0;
        end else begin
            cmp_q <= cmp_d;
            en_q  <= en_d;
            per_q <= per_d;
            ivl_q <= ivl_d;
        end
    end

endmodule

// File: rtl/mem_timer_bank.sv
// Timer/GPIO bank on a simple req/we memory port: prescaled mtime,
// compare channels, W1C interrupt status and synchronised GPIO.
module mem_timer_bank
    import mem_timer_pkg::*;
#(
    parameter int NUM_TIMERS     = 2,
    parameter int GPIO_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_be,
    input  logic [63:0]           i_wdata,
    output logic [63:0]           o_rdata,
    input  logic [GPIO_WIDTH-1:0] i_gpio,
    output logic [GPIO_WIDTH-1:0] o_gpio,
    output logic [NUM_TIMERS-1:0] o_irq,
    output logic                  o_timer_irq
);

    localparam int IW = ADDR_WIDTH - 3;
    localparam int NT = NUM_TIMERS;
    localparam int PW = PRESCALE_WIDTH;
    localparam int GW = GPIO_WIDTH;

    logic [IW-1:0] widx;
    logic          wr, rd;

    logic [63:0]   mtime_q, mtime_d;
    logic [PW-1:0] pre_q, pre_d, cnt_q, cnt_d;
    logic          en_q, en_d, tick;
    logic [NT-1:0] stat_q, stat_d, ie_q, ie_d, fire;
    logic [GW-1:0] gout_q, gout_d, sync1_q, sync2_q;
    logic [63:0]   rdata_q, rmux, ctrl_rd;
    logic [63:0]   ctrl_m, ie_m, gout_m, w1c_m;
    logic [63:0]   cmp_w [NT];
    logic [63:0]   cfg_w [NT];
    logic          unused_ok;

    assign widx = i_addr[ADDR_WIDTH-1:3];
    assign wr   = i_req & i_we;
    assign rd   = i_req & ~i_we;

    always_comb begin
        ctrl_rd = 64'(pre_q);
        ctrl_rd[CTRL_EN_BIT] = en_q;
    end

    assign ctrl_m    = be_merge(ctrl_rd, i_wdata, i_be);
    assign ie_m      = be_merge(64'(ie_q), i_wdata, i_be);
    assign gout_m    = be_merge(64'(gout_q), i_wdata, i_be);
    assign w1c_m     = be_merge(64'd0, i_wdata, i_be);
    assign unused_ok = ^{i_addr[2:0], ctrl_m, ie_m, gout_m, w1c_m};

    assign tick = en_q & (cnt_q == pre_q);

    for (genvar n = 0; n < NT; n++) begin : g_chan
        mem_timer_chan u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_mtime  (mtime_q),
            .i_cmp_we (wr && widx == IW'(REG_CMP_BASE + 2*n)),
            .i_cfg_we (wr && widx == IW'(REG_CMP_BASE + 2*n + 1)),
            .i_be     (i_be),
            .i_wdata  (i_wdata),
            .o_cmp    (cmp_w[n]),
            .o_cfg    (cfg_w[n]),
            .o_fire   (fire[n])
        );
    end

    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        pre_d   = pre_q;
        en_d    = en_q;
        cnt_d   = en_q ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
        ie_d    = ie_q;
        gout_d  = gout_q;
        stat_d  = stat_q;
        if (wr && widx == IW'(REG_MTIME))
            mtime_d = be_merge(mtime_q, i_wdata, i_be);
        if (wr && widx == IW'(REG_CTRL)) begin
            pre_d = ctrl_m[PW-1:0];
            en_d  = ctrl_m[CTRL_EN_BIT];
            cnt_d = '0;
        end
        if (wr && widx == IW'(REG_GPIO_OUT)) gout_d = gout_m[GW-1:0];
        if (wr && widx == IW'(REG_IRQ_EN))   ie_d   = ie_m[NT-1:0];
        if (wr && widx == IW'(REG_IRQ_STATUS))
            stat_d = stat_q & ~w1c_m[NT-1:0];
        // A hardware fire overrides a simultaneous W1C clear.
        stat_d = stat_d | fire;
    end

    always_comb begin
        rmux = '0;
        case (widx)
            IW'(REG_MTIME):      rmux = mtime_q;
            IW'(REG_CTRL):       rmux = ctrl_rd;
            IW'(REG_GPIO_OUT):   rmux = 64'(gout_q);
            IW'(REG_GPIO_IN):    rmux = 64'(sync2_q);
            IW'(REG_IRQ_STATUS): rmux = 64'(stat_q);
            IW'(REG_IRQ_EN):     rmux = 64'(ie_q);
            default: begin
                for (int n = 0; n < NT; n++) begin
                    if (widx == IW'(REG_CMP_BASE + 2*n))     rmux = cmp_w[n];
                    if (widx == IW'(REG_CMP_BASE + 2*n + 1)) rmux = cfg_w[n];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q     <= '0;
            pre_q       <= '0;
            cnt_q       <= '0;
            en_q        <= 1'b1;
            stat_q      <= '0;
            ie_q        <= '0;
            gout_q      <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            rdata_q     <= '0;
            o_irq       <= '0;
            o_timer_irq <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            stat_q      <= stat_d;
            ie_q        <= ie_d;
            gout_q      <= gout_d;
            sync1_q     <= i_gpio;
            sync2_q     <= sync1_q;
            if (rd) rdata_q <= rmux;
            o_irq       <= stat_d & ie_d;
            o_timer_irq <= |(stat_d & ie_d);
        end
    end

    assign o_rdata = rdata_q;
    assign o_gpio  = gout_q;

endmodule

// File: tb/tb_mem_timer_bank.sv
// Directed bench for mem_timer_bank: register access, prescaler,
// one-shot/periodic channels, collisions, wrap and GPIO.
module tb_mem_timer_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [7:0]  addr, be;
    logic [63:0] wdata, rdata;
    logic [7:0]  gpio_i, gpio_o;
    logic [1:0]  irq;
    logic        tirq;
    logic [63:0] v;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    mem_timer_bank dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_addr      (addr),
        .i_be        (be),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .i_gpio      (gpio_i),
        .o_gpio      (gpio_o),
        .o_irq       (irq),
        .o_timer_irq (tirq)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; the access lands on the next rise.
    task automatic wr_be(input logic [7:0] a, input logic [63:0] d,
                         input logic [7:0] b);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        @(negedge clk);
        req = 1'b0; we = 1'b0; be = 8'h00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        wr_be(a, d, 8'hFF);
    endtask

    task automatic rd(input logic [7:0] a, output logic [63:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        d = rdata;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0;
        addr = '0; be = '0; wdata = '0; gpio_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_irq", {62'd0, irq}, 64'd0);
        chk("rst_tirq", {63'd0, tirq}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_gpio", {56'd0, gpio_o}, 64'd0);
        rst_n = 1'b1;
        rd(8'h08, v); chk("rst_ctrl", v, 64'h1_0000_0000);
        rd(8'h00, v); chk("rst_mtime_small", {63'd0, v > 0 && v < 10}, 64'd1);
        rd(8'h40, v); chk("rst_cmp0", v, '1);
        rd(8'h48, v); chk("rst_cfg0", v, 64'd0);
        rd(8'h28, v); chk("rst_ie", v, 64'd0);

        // freeze
        wr(8'h08, 64'd0);
        wr(8'h00, 64'd1000);
        rd(8'h00, v); chk("frz_mtime", v, 64'd1000);
        repeat (100) @(negedge clk);
        rd(8'h00, v); chk("frz_mtime_100", v, 64'd1000);

        // prescale 3: one tick per 4 clocks
        wr(8'h08, 64'h1_0000_0003);
        repeat (16) @(negedge clk);
        wr(8'h08, 64'd0);
        rd(8'h00, v); chk("pre_mtime", v, 64'd1004);

        // one-shot
        wr(8'h00, 64'd0);
        wr(8'h28, 64'd1);
        wr(8'h40, 64'd20);
        wr(8'h48, 64'd1);
        wr(8'h08, 64'h1_0000_0000);
        repeat (20) @(negedge clk);
        chk("os_irq_before", {62'd0, irq}, 64'd0);
        @(negedge clk);
        chk("os_irq_fire", {62'd0, irq}, 64'd1);
        chk("os_tirq_fire", {63'd0, tirq}, 64'd1);
        rd(8'h48, v); chk("os_cfg_cleared", v, 64'd0);
        rd(8'h20, v); chk("os_status", v, 64'd1);
        wr(8'h20, 64'd1);
        chk("os_irq_w1c", {62'd0, irq}, 64'd0);
        chk("os_tirq_w1c", {63'd0, tirq}, 64'd0);

        // periodic, interval 10 from 100
        wr(8'h08, 64'd0);
        wr(8'h00, 64'd90);
        wr(8'h50, 64'd100);
        wr(8'h58, 64'h0000_000A_0000_0003);
        wr(8'h28, 64'd3);
        wr(8'h08, 64'h1_0000_0000);
        repeat (10) @(negedge clk);
        chk("per_before", {62'd0, irq}, 64'd0);
        @(negedge clk);
        chk("per_fire100", {62'd0, irq}, 64'd2);
        wr(8'h20, 64'd2);
        chk("per_clr1", {62'd0, irq}, 64'd0);
        repeat (9) @(negedge clk);
        chk("per_fire110", {62'd0, irq}, 64'd2);
        wr(8'h20, 64'd2);
        chk("per_clr2", {62'd0, irq}, 64'd0);
        repeat (9) @(negedge clk);
        chk("per_fire120", {62'd0, irq}, 64'd2);
        repeat (3) @(negedge clk);
        wr(8'h08, 64'd0);
        rd(8'h50, v); chk("per_cmp130", v, 64'd130);
        rd(8'h00, v); chk("per_mtime", v, 64'd125);

        // W1C in the fire cycle loses to the fire
        wr(8'h58, 64'd0);
        wr(8'h20, 64'd3);
        wr(8'h48, 64'd1);
        wr(8'h20, 64'd1);
        rd(8'h20, v); chk("col_w1c_status", v, 64'd1);
        rd(8'h48, v); chk("col_cfg0", v, 64'd0);
        chk("col_irq", {62'd0, irq}, 64'd1);
        wr(8'h20, 64'd1);

        // MTIME write while ticking wins over increment
        wr(8'h08, 64'h1_0000_0000);
        wr(8'h00, 64'd5000);
        wr(8'h08, 64'd0);
        rd(8'h00, v); chk("col_mtime_wr", v, 64'd5001);

        // wrap
        wr(8'h00, 64'hFFFF_FFFF_FFFF_FFFE);
        wr(8'h08, 64'h1_0000_0000);
        @(negedge clk);
        wr(8'h08, 64'd0);
        rd(8'h00, v); chk("wrap", v, 64'd0);

        // unmapped words
        rd(8'h50, v); chk("cmp1_hold", v, 64'd130);
        rd(8'hF8, v); chk("unmapped_31", v, 64'd0);
        rd(8'h30, v); chk("unmapped_6", v, 64'd0);
        wr(8'h60, 64'h1234);
        rd(8'h60, v); chk("cmp2_absent", v, 64'd0);

        // byte enables
        wr(8'h40, 64'h1122_3344_5566_7788);
        wr_be(8'h40, '1, 8'h01);
        rd(8'h40, v); chk("be_byte0", v, 64'h1122_3344_5566_77FF);
        wr_be(8'h40, 64'd0, 8'h80);
        rd(8'h40, v); chk("be_byte7", v, 64'h0022_3344_5566_77FF);

        // GPIO
        wr(8'h10, 64'hFFFF_FFFF_FFFF_FF5A);
        chk("gpio_out_pin", {56'd0, gpio_o}, 64'h5A);
        rd(8'h10, v); chk("gpio_out_rd", v, 64'h5A);
        rd(8'h18, v); chk("gpio_in_zero", v, 64'd0);
        gpio_i = 8'hC3;
        repeat (3) @(negedge clk);
        rd(8'h18, v); chk("gpio_in_sync", v, 64'hC3);

        // unused IE bits read zero
        wr(8'h28, '1);
        rd(8'h28, v); chk("ie_width", v, 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
